// File: rtl/lynx_joy_pkg.sv
// lynx_joy_pkg: shared constants and FSM state type for the serial joystick front end
package lynx_joy_pkg;
  localparam int JOY_BITS   = 12;
  localparam int FRAME_BITS = 24;
  localparam int LOAD_TICKS = 2;
  localparam int JOY_U = 0;
  localparam int JOY_D = 1;
  localparam int JOY_L = 2;
  localparam int JOY_R = 3;
  localparam int JOY_B = 4;
  localparam int JOY_C = 5;
  localparam int JOY_A = 6;
  localparam int JOY_S = 7;
  localparam int JOY_Z = 8;
  localparam int JOY_Y = 9;
  localparam int JOY_X = 10;
  localparam int JOY_M = 11;
  typedef enum logic [1:0] {LOAD, SHIFT_LO, SHIFT_HI, COMMIT} joy_state_t;
endpackage

// File: rtl/joy_tick.sv
// joy_tick: free-running prescaler, one-clock tick every DIV clocks
//   clock in  system clock
//   reset in  async active-high reset
//   tick  out high for one clock every DIV clocks, first at clock DIV-1
module joy_tick #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  // with DIV=1 the counter sits at 0 and tick stays high
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/joy_shifter.sv
// joy_shifter: clocks two chained 74HC165 pads and publishes debounced 12-bit button words
//   clock in  system clock
//   reset in  async active-high reset
//   joyD  in  serial data from the register chain
//   joyLd out parallel-load strobe, active-low
//   joyCk out shift clock, chain shifts on its rising edge
//   joy1  out pad 1 buttons MXYZ SACB RLDU, 0 = pressed
//   joy2  out pad 2 buttons, same encoding
//   frame out one-clock pulse per captured frame
module joy_shifter
  import lynx_joy_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                joyD,
  output logic                joyLd,
  output logic                joyCk,
  output logic [JOY_BITS-1:0] joy1,
  output logic [JOY_BITS-1:0] joy2,
  output logic                frame
);
  localparam int LW = (LOAD_TICKS > 1) ? $clog2(LOAD_TICKS) : 1;
  logic tick;
  joy_state_t state, state_n;
  logic [4:0] bitcnt, bitcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [FRAME_BITS-1:0] sh, sh_n, prev, prev_n, pub, pub_n;
  logic ld_n, ck_n, frame_n;
  joy_tick #(.DIV(DIV)) prescaler (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );
  assign joy1 = pub[JOY_BITS-1:0];
  assign joy2 = pub[FRAME_BITS-1:JOY_BITS];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= LOAD;
      bitcnt <= '0;
      lcnt   <= '0;
      sh     <= '1;
      prev   <= '1;
      pub    <= '1;
      joyLd  <= 1'b0;
      joyCk  <= 1'b0;
      frame  <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      lcnt   <= lcnt_n;
      sh     <= sh_n;
      prev   <= prev_n;
      pub    <= pub_n;
      joyLd  <= ld_n;
      joyCk  <= ck_n;
      frame  <= frame_n;
    end
  // joyD is captured in the same clock that raises joyCk, i.e. before the chain shifts
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    lcnt_n   = lcnt;
    sh_n     = sh;
    prev_n   = prev;
    pub_n    = pub;
    ld_n     = joyLd;
    ck_n     = joyCk;
    frame_n  = 1'b0;
    if (tick)
      case (state)
        LOAD: begin
          ld_n     = 1'b0;
          ck_n     = 1'b0;
          bitcnt_n = '0;
          lcnt_n   = (lcnt == LW'(LOAD_TICKS - 1)) ? '0 : lcnt + 1'b1;
          state_n  = (lcnt == LW'(LOAD_TICKS - 1)) ? SHIFT_LO : LOAD;
        end
        SHIFT_LO: begin
          ld_n    = 1'b1;
          ck_n    = 1'b0;
          state_n = SHIFT_HI;
        end
        SHIFT_HI: begin
          sh_n[bitcnt] = joyD;
          ck_n         = 1'b1;
          bitcnt_n     = (bitcnt == 5'(FRAME_BITS - 1)) ? bitcnt : bitcnt + 1'b1;
          state_n      = (bitcnt == 5'(FRAME_BITS - 1)) ? COMMIT : SHIFT_LO;
        end
        COMMIT: begin
          frame_n = 1'b1;
          pub_n   = (sh == prev) ? sh : pub;
          prev_n  = sh;
          state_n = LOAD;
        end
        default: state_n = LOAD;
      endcase
  end
endmodule
